// File: rtl/jtframe_dwnld_sched.sv
// ROM download scheduler: queues ioctl bytes and issues them one at a time on the SDRAM prog port.
// Optional watchdog on unacknowledged writes: define JTFRAME_DWNLD_WDOG_EN.
module jtframe_dwnld_sched #(
  parameter int AW   = 2,
  parameter int WDOG = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        sdram_ack,
  output logic        ovf,
  output logic        done,
  output logic        wdog_err
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t      state;
  logic [32:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [32:0] head;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        drop;
  logic        wdog_hit;
  logic        dl_q;
  logic        dl_rise;
  logic        active;
  logic        fin;
  logic        unused_hi;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign pop   = (state == ISSUE) && (sdram_ack || wdog_hit);
  // a full FIFO still accepts when the head leaves in the same cycle
  assign push  = ioctl_wr && downloading && (!full || pop);
  assign drop  = ioctl_wr && downloading && full && !pop;

  assign dl_rise   = downloading && !dl_q;
  assign fin       = !downloading && empty && (state == IDLE) && active;
  assign unused_hi = ^head[32:31];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {ioctl_addr, ioctl_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= '0;
      prog_we   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            prog_addr <= head[30:9];
            prog_data <= {2{head[7:0]}};
            prog_mask <= head[8] ? 2'b10 : 2'b01;
            prog_we   <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (pop) begin
            prog_we <= 1'b0;
            state   <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q   <= 1'b0;
      active <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      dl_q <= downloading;
      done <= fin;
      if (downloading) active <= 1'b1;
      else if (fin)    active <= 1'b0;
      if (dl_rise) ovf <= 1'b0;
      if (drop)    ovf <= 1'b1;
    end
  end

`ifdef JTFRAME_DWNLD_WDOG_EN
  localparam int CW = $clog2(WDOG + 1);

  logic [CW-1:0] wcnt;

  assign wdog_hit = (state == ISSUE) && !sdram_ack &&
                    (wcnt == CW'(WDOG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state != ISSUE) wcnt <= '0;
      else                wcnt <= wcnt + CW'(1);
      if (dl_rise)  wdog_err <= 1'b0;
      if (wdog_hit) wdog_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = |WDOG;
  assign wdog_hit   = 1'b0;
  assign wdog_err   = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_dwnld_sched.sv
// Directed bench for jtframe_dwnld_sched.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_jtframe_dwnld_sched;

  logic        clk;
  logic        rst_n;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        sdram_ack;
  logic        ovf;
  logic        done;
  logic        wdog_err;

  int n_chk;
  int n_fail;
  int done_cnt;
  int we_rise;
  logic we_q;

  logic [21:0] la[$];
  logic [15:0] ld[$];
  logic [1:0]  lm[$];

  jtframe_dwnld_sched #(.AW(2), .WDOG(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .sdram_ack   (sdram_ack),
    .ovf         (ovf),
    .done        (done),
    .wdog_err    (wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // log of accepted SDRAM writes and event counters
  initial begin
    done_cnt = 0;
    we_rise  = 0;
    we_q     = 1'b0;
  end

  always @(posedge clk) begin
    if (prog_we && sdram_ack) begin
      la.push_back(prog_addr);
      ld.push_back(prog_data);
      lm.push_back(prog_mask);
    end
    if (done) done_cnt++;
    if (prog_we && !we_q) we_rise++;
    we_q = prog_we;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    int d0;
    int w0;
    n_chk       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    downloading = 1'b0;
    ioctl_addr  = '0;
    ioctl_data  = '0;
    ioctl_wr    = 1'b0;
    sdram_ack   = 1'b0;
    idle(3);

    check("rst_we",   32'(prog_we),   32'h0);
    check("rst_addr", 32'(prog_addr), 32'h0);
    check("rst_data", 32'(prog_data), 32'h0);
    check("rst_mask", 32'(prog_mask), 32'h0);
    check("rst_ovf",  32'(ovf),       32'h0);
    check("rst_done", 32'(done),      32'h0);
    check("rst_wdog", 32'(wdog_err),  32'h0);
    rst_n = 1'b1;
    idle(2);

    // single byte, ack two cycles after prog_we
    downloading = 1'b1;
    base = la.size();
    w0   = we_rise;
    d0   = done_cnt;
    wr_byte(25'h000005, 8'hA5);
    idle(1);
    check("t1_we",   32'(prog_we),   32'h1);
    check("t1_addr", 32'(prog_addr), 32'h000002);
    check("t1_data", 32'(prog_data), 32'hA5A5);
    check("t1_mask", 32'(prog_mask), 32'h2);
    idle(1);
    check("t1_hold", 32'(prog_we), 32'h1);
    sdram_ack = 1'b1;
    idle(1);
    sdram_ack = 1'b0;
    check("t1_we_off", 32'(prog_we), 32'h0);
    idle(4);
    check("t1_nlog",  la.size() - base, 1);
    check("t1_pulse", we_rise - w0,     1);
    check("t1_nodone", done_cnt - d0,   0);
    downloading = 1'b0;
    idle(4);
    check("t1_done", done_cnt - d0, 1);

    // four back-to-back bytes, ack held high
    downloading = 1'b1;
    sdram_ack   = 1'b1;
    base = la.size();
    w0   = we_rise;
    d0   = done_cnt;
    for (int i = 0; i < 4; i++) wr_byte(25'h100 + 25'(i), 8'h10 + 8'(i));
    idle(20);
    check("t2_nlog",  la.size() - base, 4);
    check("t2_pulse", we_rise - w0,     4);
    check("t2_ovf",   32'(ovf),         32'h0);
    check("t2_a0", 32'(la[base]),   32'h80);
    check("t2_a1", 32'(la[base+1]), 32'h80);
    check("t2_a2", 32'(la[base+2]), 32'h81);
    check("t2_a3", 32'(la[base+3]), 32'h81);
    check("t2_d0", 32'(ld[base]),   32'h1010);
    check("t2_d3", 32'(ld[base+3]), 32'h1313);
    check("t2_m0", 32'(lm[base]),   32'h1);
    check("t2_m1", 32'(lm[base+1]), 32'h2);
    check("t2_nodone", done_cnt - d0, 0);
    downloading = 1'b0;
    idle(4);
    sdram_ack = 1'b0;
    check("t2_done", done_cnt - d0, 1);
    idle(6);
    check("t2_done_once", done_cnt - d0, 1);

    // six bytes with ack withheld: the last two are dropped
    downloading = 1'b1;
    base = la.size();
    d0   = done_cnt;
    for (int i = 0; i < 6; i++) wr_byte(25'h200 + 25'(i), 8'h20 + 8'(i));
    check("t3_ovf",   32'(ovf),         32'h1);
    check("t3_stall", 32'(prog_we),     32'h1);
    check("t3_nlog0", la.size() - base, 0);
    sdram_ack = 1'b1;
    idle(20);
    sdram_ack = 1'b0;
    check("t3_nlog", la.size() - base, 4);
    check("t3_a0", 32'(la[base]),   32'h100);
    check("t3_a3", 32'(la[base+3]), 32'h101);
    check("t3_d1", 32'(ld[base+1]), 32'h2121);
    check("t3_d3", 32'(ld[base+3]), 32'h2323);
    check("t3_m3", 32'(lm[base+3]), 32'h2);
    downloading = 1'b0;
    idle(4);
    check("t3_done",   done_cnt - d0, 1);
    check("t3_sticky", 32'(ovf),      32'h1);
    downloading = 1'b1;
    idle(2);
    check("t3_ovf_clr", 32'(ovf), 32'h0);

    // reset while a write is pending
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) wr_byte(25'h400 + 25'(i), 8'h40 + 8'(i));
    check("t4_we_pre", 32'(prog_we), 32'h1);
    w0 = we_rise;
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_we_async", 32'(prog_we), 32'h0);
    downloading = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    check("t4_no_we",   we_rise - w0,  0);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_we_low",  32'(prog_we),  32'h0);

    // no ack at all: watchdog behaviour depends on the build
    downloading = 1'b1;
    base = la.size();
    wr_byte(25'h300, 8'hAA);
    wr_byte(25'h302, 8'hBB);
    idle(7);
    check("t5_we_8", 32'(prog_we), 32'h1);
    idle(1);
`ifdef JTFRAME_DWNLD_WDOG_EN
    check("t5_we_drop", 32'(prog_we),  32'h0);
    check("t5_wdog",    32'(wdog_err), 32'h1);
    idle(2);
    check("t5_next_we",   32'(prog_we),   32'h1);
    check("t5_next_addr", 32'(prog_addr), 32'h181);
    check("t5_next_data", 32'(prog_data), 32'hBBBB);
`else
    check("t5_we_hold", 32'(prog_we),  32'h1);
    check("t5_wdog",    32'(wdog_err), 32'h0);
    idle(20);
    check("t5_still_we",  32'(prog_we),   32'h1);
    check("t5_same_addr", 32'(prog_addr), 32'h180);
`endif
    check("t5_nlog", la.size() - base, 0);
    rst_n       = 1'b0;
    downloading = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
